// File: rtl/riscv_pkg.sv
// Shared RV64 core types; M-extension op encoding plus the iterative mul/div unit's state and helpers.
package riscv_pkg;

    typedef enum logic [3:0] {
        M_NONE,
        M_MUL,
        M_MULH,
        M_MULHSU,
        M_MULHU,
        M_DIV,
        M_DIVU,
        M_REM,
        M_REMU,
        M_MULW,
        M_DIVW,
        M_DIVUW,
        M_REMW,
        M_REMUW
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } md_state_t;

    localparam int unsigned MD_ITER_D = 64;
    localparam int unsigned MD_ITER_W = 32;
    localparam int unsigned MD_CNT_W  = 6;

    function automatic logic md_is_w(input mul_op_t op);
        return op inside {M_MULW, M_DIVW, M_DIVUW, M_REMW, M_REMUW};
    endfunction

    // Whole divide family, remainders included.
    function automatic logic md_is_div(input mul_op_t op);
        return op inside {M_DIV, M_DIVU, M_REM, M_REMU, M_DIVW, M_DIVUW, M_REMW, M_REMUW};
    endfunction

    function automatic logic md_is_rem(input mul_op_t op);
        return op inside {M_REM, M_REMU, M_REMW, M_REMUW};
    endfunction

    function automatic logic md_a_signed(input mul_op_t op);
        return op inside {M_MULH, M_MULHSU, M_DIV, M_REM, M_DIVW, M_REMW};
    endfunction

    function automatic logic md_b_signed(input mul_op_t op);
        return op inside {M_MULH, M_DIV, M_REM, M_DIVW, M_REMW};
    endfunction

    function automatic logic [63:0] md_sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_special.sv
// Divide special-case detector: divide-by-zero and signed MIN/-1 overflow, with the bypass result.
module muldiv_special
    import riscv_pkg::*;
(
    input  mul_op_t      op_i,
    input  logic [63:0]  a_i,
    input  logic [63:0]  b_i,
    output logic         special_c,
    output logic [63:0]  result_c
);

    logic is_w;
    logic b_zero;
    logic a_min;
    logic b_m1;
    logic ovf;

    always_comb begin
        is_w      = md_is_w(op_i);
        b_zero    = is_w ? (b_i[31:0] == 32'd0) : (b_i == 64'd0);
        a_min     = is_w ? (a_i[31:0] == 32'h8000_0000) : (a_i == 64'h8000_0000_0000_0000);
        b_m1      = is_w ? (b_i[31:0] == 32'hFFFF_FFFF) : (b_i == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf       = md_is_div(op_i) && md_a_signed(op_i) && a_min && b_m1;
        special_c = md_is_div(op_i) && (b_zero || ovf);
        result_c  = '0;
        if (b_zero) begin
            if (md_is_rem(op_i)) result_c = is_w ? md_sext32(a_i[31:0]) : a_i;
            else                 result_c = '1;
        end else if (ovf && !md_is_rem(op_i)) begin
            result_c = is_w ? md_sext32(32'h8000_0000) : 64'h8000_0000_0000_0000;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiply and restoring divide on magnitudes,
// sign fix-up in a final cycle, result held in DONE until writeback accepts it.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  mul_op_t         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            busy_o
);

    localparam int unsigned AW = 2 * XLEN;

    md_state_t              state_q, state_d;
    logic                   accept_c;
    logic [MD_CNT_W-1:0]    cnt_q;
    logic [AW-1:0]          acc_q;
    logic [XLEN-1:0]        opb_q;
    mul_op_t                op_q;
    logic                   neg_a_q, neg_b_q;

    logic                   spec_c;
    logic [XLEN-1:0]        spec_res_c;

    muldiv_special u_special (
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .special_c (spec_c),
        .result_c  (spec_res_c)
    );

    // Operand conditioning at issue: W narrowing, sign flags and magnitudes.
    logic            is_w_c;
    logic            a_sgn_c, b_sgn_c;
    logic [XLEN-1:0] a_ext_c, b_ext_c, a_mag_c, b_mag_c;

    always_comb begin
        is_w_c = md_is_w(op_i);
        a_ext_c = a_i;
        b_ext_c = b_i;
        if (is_w_c) begin
            a_ext_c = md_a_signed(op_i) ? md_sext32(a_i[31:0]) : XLEN'(a_i[31:0]);
            b_ext_c = md_b_signed(op_i) ? md_sext32(b_i[31:0]) : XLEN'(b_i[31:0]);
        end
        a_sgn_c = md_a_signed(op_i) && a_ext_c[XLEN-1];
        b_sgn_c = md_b_signed(op_i) && b_ext_c[XLEN-1];
        a_mag_c = a_sgn_c ? -a_ext_c : a_ext_c;
        b_mag_c = b_sgn_c ? -b_ext_c : b_ext_c;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && ready_o && op_i != M_NONE) begin
                    accept_c = 1'b1;
                    state_d  = spec_c ? DONE : ITER;
                end
            end
            ITER:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (valid_o && ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d  = IDLE;
            accept_c = 1'b0;
        end
    end

    // One iteration step: multiply adds the multiplicand on the low multiplier bit and shifts
    // right; divide shifts the dividend MSB into the partial remainder and subtracts if it fits.
    logic [XLEN:0]   mul_sum_c, div_sh_c;
    logic [XLEN-1:0] div_diff_c;
    logic            div_ge_c;
    logic [AW-1:0]   mul_step_c, div_step_c;

    always_comb begin
        mul_sum_c  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
        div_sh_c   = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
        div_ge_c   = div_sh_c >= {1'b0, opb_q};
        div_diff_c = div_sh_c[XLEN-1:0] - opb_q;
        div_step_c = {(div_ge_c ? div_diff_c : div_sh_c[XLEN-1:0]), acc_q[XLEN-2:0], div_ge_c};
    end

    logic            neg_p_c;
    logic [AW-1:0]   prod_c;
    logic [XLEN-1:0] quo_c, rem_c, fix_res_c;

    always_comb begin
        neg_p_c   = neg_a_q ^ neg_b_q;
        prod_c    = neg_p_c ? -acc_q : acc_q;
        quo_c     = neg_p_c ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_c     = neg_a_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
        fix_res_c = '0;
        case (op_q)
            M_MUL:                     fix_res_c = prod_c[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: fix_res_c = prod_c[AW-1:XLEN];
            M_MULW:                    fix_res_c = md_sext32(acc_q[63:32]);
            M_DIV, M_DIVU:             fix_res_c = quo_c;
            M_REM, M_REMU:             fix_res_c = rem_c;
            M_DIVW, M_DIVUW:           fix_res_c = md_sext32(quo_c[31:0]);
            M_REMW, M_REMUW:           fix_res_c = md_sext32(rem_c[31:0]);
            default:                   fix_res_c = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            ready_o   <= 1'b1;
            result_o  <= '0;
            rd_addr_o <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= M_NONE;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
        end else begin
            valid_o <= (state_d == DONE);
            busy_o  <= (state_d != IDLE);
            ready_o <= (state_d == IDLE);
            if (accept_c) begin
                op_q      <= op_i;
                neg_a_q   <= a_sgn_c;
                neg_b_q   <= b_sgn_c;
                rd_addr_o <= rd_addr_i;
                cnt_q     <= is_w_c ? MD_CNT_W'(MD_ITER_W - 1) : MD_CNT_W'(MD_ITER_D - 1);
                if (md_is_div(op_i)) begin
                    opb_q <= b_mag_c;
                    acc_q <= {XLEN'(0), (is_w_c ? {a_mag_c[31:0], 32'd0} : a_mag_c)};
                end else begin
                    opb_q <= a_mag_c;
                    acc_q <= {XLEN'(0), b_mag_c};
                end
                if (spec_c) result_o <= spec_res_c;
            end else if (state_q == ITER) begin
                cnt_q <= cnt_q - 1'b1;
                acc_q <= md_is_div(op_q) ? div_step_c : mul_step_c;
            end else if (state_q == FIX) begin
                result_o <= fix_res_c;
            end
        end
    end

endmodule
